frame_strobe_writer: RTL and testbench

Write-side driver for the tile configuration frame latches of one fabric column. It accepts a stream of 32-bit configuration words, assembles one frame's data for every row, then issues a single-cycle one-hot strobe on the selected frame line. It sits between the bitstream/USB config controller and the `FrameData`/`FrameStrobe` nets that feed each tile's frame latches.

---
 rtl/frame_cfg_pkg.sv | 23 ++
 rtl/frame_row_buffer.sv | 34 +++
 rtl/frame_strobe_writer.sv | 144 ++++++++++++++
 tb/tb_frame_strobe_writer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg: shared definitions for the column frame writer.
//   state_e        - writer FSM states
//   SYNC_BYTE      - default header sync byte
//   SYNC_*/IDX_*   - header field positions
package frame_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DROP   = 3'd4
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hFA;

  localparam int SYNC_MSB = 31;
  localparam int SYNC_LSB = 24;
  localparam int IDX_MSB  = 4;
  localparam int IDX_LSB  = 0;
  localparam int IDX_W    = IDX_MSB - IDX_LSB + 1;

endpackage

// File: rtl/frame_row_buffer.sv
// frame_row_buffer: Rows x RowW register file, one write port, all rows
// visible at once on a flat bus (row r at [r*RowW +: RowW]).
//   gclk, grst_n - clock, async active-low reset (clears all rows)
//   we, waddr    - write enable and row address
//   wdata        - row write data
//   rows_flat    - concatenated row contents
module frame_row_buffer #(
  parameter int Rows  = 16,
  parameter int RowW  = 32,
  parameter int AddrW = 4
) (
  input  logic                 gclk,
  input  logic                 grst_n,
  input  logic                 we,
  input  logic [AddrW-1:0]     waddr,
  input  logic [RowW-1:0]      wdata,
  output logic [Rows*RowW-1:0] rows_flat
);

  for (genvar r = 0; r < Rows; r++) begin : g_row
    logic [RowW-1:0] row_q;
    logic [RowW-1:0] row_d;

    always_comb row_d = (we && (waddr == AddrW'(r))) ? wdata : row_q;

    always_ff @(posedge gclk or negedge grst_n) begin
      if (!grst_n) row_q <= '0;
      else         row_q <= row_d;
    end

    assign rows_flat[r*RowW +: RowW] = row_q;
  end

endmodule

// File: rtl/frame_strobe_writer.sv
// frame_strobe_writer: assembles one configuration frame (one word per row)
// from a header + NumberOfRows data words, then pulses the selected frame
// strobe line for one cycle.
//   CLK, resetn    - clock, async active-low reset
//   WordData/Valid - input word stream; WordReady is the accept handshake
//   FrameData      - assembled frame, row r at [r*32 +: 32]
//   FrameStrobe    - one-hot single-cycle write pulse
//   Busy           - not IDLE
//   FrameError     - sticky: bad sync byte or out-of-range frame index
//   FramesWritten  - strobes issued, wraps at 16 bits
module frame_strobe_writer
  import frame_cfg_pkg::*;
#(
  parameter int         MaxFramesPerCol = 20,
  parameter int         FrameBitsPerRow = 32,
  parameter int         NumberOfRows    = 16,
  parameter logic [7:0] SyncByte        = SYNC_BYTE
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [31:0]                             WordData,
  input  logic                                    WordValid,
  output logic                                    WordReady,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    Busy,
  output logic                                    FrameError,
  output logic [15:0]                             FramesWritten
);

  localparam int RowAW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam logic [RowAW-1:0] LastRow = RowAW'(NumberOfRows - 1);
  localparam logic [MaxFramesPerCol-1:0] StrobeOne = MaxFramesPerCol'(1);

  state_e                     state_q, state_d;
  logic [RowAW-1:0]           rowcnt_q, rowcnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;
  logic [15:0]                cnt_q, cnt_d;

  logic             acc;
  logic             row_we;
  logic [7:0]       hdr_sync;
  logic [IDX_W-1:0] hdr_idx;
  logic             idx_ok;

  assign acc      = WordValid & ready_q;
  assign hdr_sync = WordData[SYNC_MSB:SYNC_LSB];
  assign hdr_idx  = WordData[IDX_MSB:IDX_LSB];
  assign idx_ok   = 32'(hdr_idx) < 32'(MaxFramesPerCol);

  always_comb begin
    state_d  = state_q;
    rowcnt_d = rowcnt_q;
    idx_d    = idx_q;
    strobe_d = '0;
    err_d    = err_q;
    cnt_d    = cnt_q;
    row_we   = 1'b0;

    case (state_q)
      IDLE: if (acc) begin
        if (hdr_sync != SyncByte) begin
          err_d = 1'b1;                // discard, stay in IDLE
        end else if (idx_ok) begin
          idx_d    = hdr_idx;
          rowcnt_d = '0;
          state_d  = LOAD;
        end else begin
          err_d    = 1'b1;
          rowcnt_d = '0;
          state_d  = DROP;
        end
      end
      LOAD: if (acc) begin
        row_we = 1'b1;
        if (rowcnt_q == LastRow) begin
          // Strobe is registered on entry so it is high for the whole STROBE cycle.
          strobe_d = StrobeOne << idx_q;
          cnt_d    = cnt_q + 16'd1;
          state_d  = STROBE;
        end else begin
          rowcnt_d = rowcnt_q + RowAW'(1);
        end
      end
      STROBE: state_d = HOLD;
      HOLD:   state_d = IDLE;
      DROP: if (acc) begin
        if (rowcnt_q == LastRow) state_d = IDLE;
        else                     rowcnt_d = rowcnt_q + RowAW'(1);
      end
      default: state_d = IDLE;
    endcase

    // Handshake and busy are registered from the next state: no path from WordValid.
    ready_d = (state_d == IDLE) || (state_d == LOAD) || (state_d == DROP);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      rowcnt_q <= '0;
      idx_q    <= '0;
      strobe_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rowcnt_q <= rowcnt_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  frame_row_buffer #(
    .Rows  (NumberOfRows),
    .RowW  (FrameBitsPerRow),
    .AddrW (RowAW)
  ) u_rows (
    .gclk      (CLK),
    .grst_n    (resetn),
    .we        (row_we),
    .waddr     (rowcnt_q),
    .wdata     (WordData),
    .rows_flat (FrameData)
  );

  assign WordReady     = ready_q;
  assign FrameStrobe   = strobe_q;
  assign Busy          = busy_q;
  assign FrameError    = err_q;
  assign FramesWritten = cnt_q;

endmodule

// File: tb/tb_frame_strobe_writer.sv
module tb_frame_strobe_writer;

  localparam int NR = 16;
  localparam int NF = 20;

  logic           CLK = 1'b0;
  logic           resetn;
  logic [31:0]    WordData;
  logic           WordValid;
  logic           WordReady;
  logic [NR*32-1:0] FrameData;
  logic [NF-1:0]  FrameStrobe;
  logic           Busy;
  logic           FrameError;
  logic [15:0]    FramesWritten;

  frame_strobe_writer dut (
    .CLK           (CLK),
    .resetn        (resetn),
    .WordData      (WordData),
    .WordValid     (WordValid),
    .WordReady     (WordReady),
    .FrameData     (FrameData),
    .FrameStrobe   (FrameStrobe),
    .Busy          (Busy),
    .FrameError    (FrameError),
    .FramesWritten (FramesWritten)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;
  int hdr_cyc = 0;
  int strobes_seen = 0;

  // Reference state: what the frame latches bus, counter and error flag should hold.
  logic [31:0] exp_rows [NR];
  int          exp_cnt;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge CLK) cyc++;

  always @(negedge CLK or negedge resetn) begin
    if (!resetn) strobes_seen = 0;
    else if (FrameStrobe != '0) begin
      strobes_seen++;
      chk("strobe_onehot", $countones(FrameStrobe), 1);
    end
  end

  // Present one word after 'gap' idle cycles; returns just after the accepting edge.
  task automatic push(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) begin @(posedge CLK); #1; end
    WordValid = 1'b1;
    WordData  = w;
    n = 0;
    while (!WordReady && n < 40) begin @(posedge CLK); #1; n++; end
    if (n >= 40) chk("accept_timeout", 32'(n), 0);
    @(posedge CLK); #1;
    last_acc  = cyc;
    WordValid = 1'b0;
    WordData  = $urandom;
  endtask

  task automatic chk_rows(input string tag);
    for (int r = 0; r < NR; r++)
      chk($sformatf("%s_row%0d", tag, r), FrameData[r*32 +: 32], exp_rows[r]);
  endtask

  task automatic do_frame(input logic [7:0] sync, input int idx, input int maxgap, input bit seq);
    logic [31:0] w [NR];
    logic [31:0] hdr;
    bit ok_sync, ok_idx;
    hdr     = {sync, 19'h0, 5'(idx)};
    ok_sync = (sync == 8'hFA);
    ok_idx  = (idx < NF);
    push(hdr, $urandom_range(0, maxgap));
    hdr_cyc = last_acc;
    if (!ok_sync) begin
      exp_err = 1'b1;
      chk("badsync_ready", 32'(WordReady), 1);
      chk("badsync_busy", 32'(Busy), 0);
      chk("badsync_err", 32'(FrameError), 1);
      return;
    end
    if (!ok_idx) exp_err = 1'b1;
    for (int r = 0; r < NR; r++) begin
      w[r] = seq ? 32'h1000_0000 + 32'(r) : $urandom;
      push(w[r], $urandom_range(0, maxgap));
    end
    if (ok_idx) begin
      for (int r = 0; r < NR; r++) exp_rows[r] = w[r];
      exp_cnt = (exp_cnt + 1) % 65536;
      chk("strobe", 32'(FrameStrobe), 32'(1) << idx);
      chk("strobe_ready", 32'(WordReady), 0);
      chk("strobe_busy", 32'(Busy), 1);
      chk_rows("strobe");
      chk("cnt", 32'(FramesWritten), 32'(exp_cnt));
      @(posedge CLK); #1;
      chk("hold_strobe", 32'(FrameStrobe), 0);
      chk("hold_ready", 32'(WordReady), 0);
      chk_rows("hold");
      @(posedge CLK); #1;
      chk("idle_ready", 32'(WordReady), 1);
    end else begin
      chk("drop_strobe", 32'(FrameStrobe), 0);
      chk("drop_ready", 32'(WordReady), 1);
      chk_rows("drop");
      chk("drop_cnt", 32'(FramesWritten), 32'(exp_cnt));
    end
    chk("idle_busy", 32'(Busy), 0);
    chk("err", 32'(FrameError), 32'(exp_err));
    chk("strobes_seen", 32'(strobes_seen), 32'(exp_cnt));
  endtask

  task automatic model_reset();
    for (int r = 0; r < NR; r++) exp_rows[r] = '0;
    exp_cnt = 0;
    exp_err = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(WordReady), 1);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_err"}, 32'(FrameError), 0);
    chk({tag, "_cnt"}, 32'(FramesWritten), 0);
    chk({tag, "_strobe"}, 32'(FrameStrobe), 0);
    chk({tag, "_data"}, 32'(FrameData != '0), 0);
  endtask

  initial begin
    int t0;
    logic [7:0] s;
    resetn    = 1'b0;
    WordValid = 1'b0;
    WordData  = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_vals("rst");
    resetn = 1'b1;
    @(posedge CLK); #1;

    // Directed: index 3, sequential data, no gaps.
    do_frame(8'hFA, 3, 0, 1'b1);

    // Index 19 back to back: headers 19 cycles apart.
    do_frame(8'hFA, 19, 0, 1'b0);
    t0 = hdr_cyc;
    do_frame(8'hFA, 19, 0, 1'b0);
    chk("throughput", 32'(hdr_cyc - t0), 19);

    // Out-of-range index is dropped; bad sync stays idle; valid frame still works.
    do_frame(8'hFA, 20, 0, 1'b0);
    do_frame(8'hAB, 1, 0, 1'b0);
    do_frame(8'hFA, 0, 2, 1'b0);

    // Reset after 7 data words: asynchronous clear, no strobe.
    push(32'hFA00_0005, 0);
    for (int r = 0; r < 7; r++) push($urandom, 0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk_reset_vals("midrst");
    @(posedge CLK); #1;
    resetn = 1'b1;
    @(posedge CLK); #1;
    do_frame(8'hFA, 5, 0, 1'b1);

    // Randomized frames with random valid gaps and occasional bad headers.
    for (int k = 0; k < 14; k++) begin
      s = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255)) : 8'hFA;
      do_frame(s, $urandom_range(0, 23), 3, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
